// File: rtl/control_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, ALU selects,
// sequencer states and the execute-class decode used from T3 onward.
package control_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  typedef enum logic [3:0] {
    ST_IDLE, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_LDI, CLS_ADDI, CLS_ALU, CLS_LD, CLS_ST, CLS_ILL
  } op_class_e;

  // nop and halt never reach T3, so they fall into the illegal class here
  function automatic op_class_e classify(input logic [4:0] op);
    case (op)
      OP_LDI:                        return CLS_LDI;
      OP_ADDI:                       return CLS_ADDI;
      OP_LD:                         return CLS_LD;
      OP_ST:                         return CLS_ST;
      OP_ADD, OP_SUB, OP_AND, OP_OR: return CLS_ALU;
      default:                       return CLS_ILL;
    endcase
  endfunction

  function automatic alu_op_e alu_map(input logic [4:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_wait_timer.sv
// 4-bit down-counter for memory hold steps: load sets the count, it then
// decrements once per clock and sticks at zero; zero flags the final hold cycle.
module control_wait_timer (
  input  logic       clock,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] count,
  output logic       zero
);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (!zero) begin
      count <= count - 4'd1;
    end
  end

  assign zero = (count == 4'd0);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch T0-T2 then opcode-dependent execute T3-T7,
// one step per clock except memory hold steps (MEM_WAIT+1 clocks); run gates new fetches.
module control_sequencer
  import control_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int MEM_WAIT = 0,
  parameter int ALUOP_W  = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                MD_read,
  output logic                IRin,
  output logic                Yin,
  output logic                Zlowin,
  output logic                Zlowout,
  output logic                Csignout,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rin,
  output logic                Rout,
  output logic                BAout,
  output logic                Read,
  output logic                Write,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                instr_done,
  output logic                illegal,
  output logic                halted
);

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_e    state, state_next;
  op_class_e cls;
  alu_op_e   alu_sel;
  logic [3:0] wait_cnt;
  logic       wait_zero, wait_load, first_hold;
  state_e     done_next;

  control_wait_timer u_wait (
    .clock    (clock),
    .clear    (clear),
    .load     (wait_load),
    .load_val (WAIT_INIT),
    .count    (wait_cnt),
    .zero     (wait_zero)
  );

  // The counter starts at MEM_WAIT, so this marks the first cycle of a hold step
  assign first_hold = (wait_cnt == WAIT_INIT);
  assign done_next  = run ? ST_T0 : ST_IDLE;
  assign wait_load  = (state_next != state) &&
                      (state_next == ST_T1 || state_next == ST_T6 || state_next == ST_T7);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= ST_IDLE;
      cls     <= CLS_ILL;
      alu_sel <= ALU_ADD;
    end else begin
      state <= state_next;
      if (state == ST_T2) begin
        cls     <= classify(opcode);
        alu_sel <= alu_map(opcode);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: state_next = run ? ST_T0 : ST_IDLE;
      ST_T0:   state_next = ST_T1;
      ST_T1:   state_next = wait_zero ? ST_T2 : ST_T1;
      ST_T2: begin
        if (opcode == OP_NOP)       state_next = done_next;
        else if (opcode == OP_HALT) state_next = ST_HALT;
        else                        state_next = ST_T3;
      end
      ST_T3:   state_next = (cls == CLS_ILL) ? done_next : ST_T4;
      ST_T4:   state_next = ST_T5;
      ST_T5:   state_next = (cls == CLS_LD || cls == CLS_ST) ? ST_T6 : done_next;
      ST_T6:   state_next = (cls == CLS_ST || wait_zero) ? ST_T7 : ST_T6;
      ST_T7:   state_next = (cls == CLS_LD || wait_zero) ? done_next : ST_T7;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read, IRin} = '0;
    {Yin, Zlowin, Zlowout, Csignout, Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    {Read, Write, instr_done, illegal, halted} = '0;
    alu_op = '0;
    case (state)
      ST_T0: {PCout, MARin, IncPC, Zlowin} = '1;
      ST_T1: begin
        {Read, MD_read, MDRin} = '1;
        Zlowout = first_hold;
        PCin    = first_hold;
      end
      ST_T2: begin
        {MDRout, IRin} = '1;
        instr_done = (opcode == OP_NOP);
      end
      ST_T3: begin
        if (cls == CLS_ILL) begin
          {illegal, instr_done} = '1;
        end else if (cls == CLS_ALU || cls == CLS_ADDI) begin
          {Grb, Rout, Yin} = '1;
        end else begin
          {Grb, BAout, Yin} = '1;
        end
      end
      ST_T4: begin
        if (cls == CLS_ALU) begin
          {Grc, Rout, Zlowin} = '1;
          alu_op = ALUOP_W'(alu_sel);
        end else begin
          {Csignout, Zlowin} = '1;
        end
      end
      ST_T5: begin
        if (cls == CLS_LD || cls == CLS_ST) {Zlowout, MARin} = '1;
        else {Zlowout, Gra, Rin, instr_done} = '1;
      end
      ST_T6: begin
        if (cls == CLS_ST) {Gra, Rout, MDRin} = '1;
        else {Read, MD_read, MDRin} = '1;
      end
      ST_T7: begin
        if (cls == CLS_ST) begin
          Write      = 1'b1;
          instr_done = wait_zero;
        end else begin
          {MDRout, Gra, Rin, instr_done} = '1;
        end
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: three sequencers (MEM_WAIT 0, 2, 1) share inputs; each
// instruction is stepped clock by clock against hand-written strobe vectors.
module tb_control_sequencer;

  logic       clock;
  logic       clear;
  logic       run;
  logic [4:0] opcode;

  int n_checks = 0;
  int n_errors = 0;

  // {halted, illegal, instr_done, alu_op[3:0], Write..PCout}
  wire [26:0] obs_v [3];

  localparam logic [26:0] PCOUT  = 27'd1 << 0;
  localparam logic [26:0] PCIN   = 27'd1 << 1;
  localparam logic [26:0] INCPC  = 27'd1 << 2;
  localparam logic [26:0] MARIN  = 27'd1 << 3;
  localparam logic [26:0] MDRIN  = 27'd1 << 4;
  localparam logic [26:0] MDROUT = 27'd1 << 5;
  localparam logic [26:0] MDREAD = 27'd1 << 6;
  localparam logic [26:0] IRIN   = 27'd1 << 7;
  localparam logic [26:0] YIN    = 27'd1 << 8;
  localparam logic [26:0] ZLIN   = 27'd1 << 9;
  localparam logic [26:0] ZLOUT  = 27'd1 << 10;
  localparam logic [26:0] CSIGN  = 27'd1 << 11;
  localparam logic [26:0] GRA    = 27'd1 << 12;
  localparam logic [26:0] GRB    = 27'd1 << 13;
  localparam logic [26:0] GRC    = 27'd1 << 14;
  localparam logic [26:0] RIN    = 27'd1 << 15;
  localparam logic [26:0] ROUT   = 27'd1 << 16;
  localparam logic [26:0] BAOUT  = 27'd1 << 17;
  localparam logic [26:0] READ   = 27'd1 << 18;
  localparam logic [26:0] WRITE  = 27'd1 << 19;
  localparam logic [26:0] ALU_SUB_V = 27'd1 << 20;
  localparam logic [26:0] DONE   = 27'd1 << 24;
  localparam logic [26:0] ILL    = 27'd1 << 25;
  localparam logic [26:0] HALT   = 27'd1 << 26;

  localparam logic [26:0] F_T0   = PCOUT | MARIN | INCPC | ZLIN;
  localparam logic [26:0] F_T1A  = READ | MDREAD | MDRIN | ZLOUT | PCIN;
  localparam logic [26:0] F_T1B  = READ | MDREAD | MDRIN;
  localparam logic [26:0] F_T2   = MDROUT | IRIN;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, MD_read, IRin;
    logic Yin, Zlowin, Zlowout, Csignout, Gra, Grb, Grc, Rin, Rout, BAout;
    logic Read, Write, instr_done, illegal, halted;
    logic [3:0] alu_op;

    control_sequencer #(
      .OPCODE_W (5),
      .MEM_WAIT (g == 0 ? 0 : (g == 1 ? 2 : 1)),
      .ALUOP_W  (4)
    ) u_dut (
      .clock      (clock),
      .clear      (clear),
      .run        (run),
      .opcode     (opcode),
      .PCout      (PCout),
      .PCin       (PCin),
      .IncPC      (IncPC),
      .MARin      (MARin),
      .MDRin      (MDRin),
      .MDRout     (MDRout),
      .MD_read    (MD_read),
      .IRin       (IRin),
      .Yin        (Yin),
      .Zlowin     (Zlowin),
      .Zlowout    (Zlowout),
      .Csignout   (Csignout),
      .Gra        (Gra),
      .Grb        (Grb),
      .Grc        (Grc),
      .Rin        (Rin),
      .Rout       (Rout),
      .BAout      (BAout),
      .Read       (Read),
      .Write      (Write),
      .alu_op     (alu_op),
      .instr_done (instr_done),
      .illegal    (illegal),
      .halted     (halted)
    );

    assign obs_v[g] = {halted, illegal, instr_done, alu_op, Write, Read, BAout, Rout, Rin,
                       Grc, Grb, Gra, Csignout, Zlowout, Zlowin, Yin, IRin, MD_read,
                       MDRout, MDRin, MARin, IncPC, PCin, PCout};
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [26:0] got, input logic [26:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and compare instance g, sampled 2 time units after the edge
  task automatic cyc(input int g, input string tag, input logic [26:0] e);
    @(posedge clock);
    #2;
    check(tag, obs_v[g], e);
  endtask

  task automatic do_reset(input int g, input string tag);
    clear = 1'b0;
    run   = 1'b0;
    #3;
    check(tag, obs_v[g], 27'd0);
    @(posedge clock);
    #2;
  endtask

  task automatic start(input logic [4:0] op);
    opcode = op;
    run    = 1'b1;
    clear  = 1'b1;
  endtask

  initial begin
    clear  = 1'b0;
    run    = 1'b0;
    opcode = 5'b00000;

    // add, MEM_WAIT=0: six clocks, then straight back to T0
    do_reset(0, "reset_w0");
    start(5'b00011);
    cyc(0, "add_t0", F_T0);
    cyc(0, "add_t1", F_T1A);
    cyc(0, "add_t2", F_T2);
    cyc(0, "add_t3", GRB | ROUT | YIN);
    cyc(0, "add_t4", GRC | ROUT | ZLIN);
    cyc(0, "add_t5", ZLOUT | GRA | RIN | DONE);
    cyc(0, "add_next_t0", F_T0);

    // ld, MEM_WAIT=2: two three-clock reads, done at clock 12, then idle
    do_reset(1, "reset_w2");
    start(5'b00000);
    cyc(1, "ld_t0", F_T0);
    cyc(1, "ld_t1a", F_T1A);
    cyc(1, "ld_t1b", F_T1B);
    cyc(1, "ld_t1c", F_T1B);
    cyc(1, "ld_t2", F_T2);
    cyc(1, "ld_t3", GRB | BAOUT | YIN);
    cyc(1, "ld_t4", CSIGN | ZLIN);
    cyc(1, "ld_t5", ZLOUT | MARIN);
    cyc(1, "ld_t6a", READ | MDREAD | MDRIN);
    cyc(1, "ld_t6b", READ | MDREAD | MDRIN);
    cyc(1, "ld_t6c", READ | MDREAD | MDRIN);
    cyc(1, "ld_t7", MDROUT | GRA | RIN | DONE);
    run = 1'b0;
    cyc(1, "ld_idle", 27'd0);
    cyc(1, "idle_stay", 27'd0);

    // nop, MEM_WAIT=2: done in T2
    do_reset(1, "reset_nop");
    start(5'b11010);
    cyc(1, "nop_t0", F_T0);
    cyc(1, "nop_t1a", F_T1A);
    cyc(1, "nop_t1b", F_T1B);
    cyc(1, "nop_t1c", F_T1B);
    cyc(1, "nop_t2", F_T2 | DONE);
    cyc(1, "nop_next_t0", F_T0);

    // st, MEM_WAIT=1: ten clocks, two-clock write
    do_reset(2, "reset_w1");
    start(5'b00010);
    cyc(2, "st_t0", F_T0);
    cyc(2, "st_t1a", F_T1A);
    cyc(2, "st_t1b", F_T1B);
    cyc(2, "st_t2", F_T2);
    cyc(2, "st_t3", GRB | BAOUT | YIN);
    cyc(2, "st_t4", CSIGN | ZLIN);
    cyc(2, "st_t5", ZLOUT | MARIN);
    cyc(2, "st_t6", GRA | ROUT | MDRIN);
    cyc(2, "st_t7a", WRITE);
    cyc(2, "st_t7b", WRITE | DONE);
    cyc(2, "st_next_t0", F_T0);

    // sub then an undefined opcode
    do_reset(0, "reset_sub");
    start(5'b00100);
    cyc(0, "sub_t0", F_T0);
    cyc(0, "sub_t1", F_T1A);
    cyc(0, "sub_t2", F_T2);
    cyc(0, "sub_t3", GRB | ROUT | YIN);
    cyc(0, "sub_t4", GRC | ROUT | ZLIN | ALU_SUB_V);
    cyc(0, "sub_t5", ZLOUT | GRA | RIN | DONE);
    opcode = 5'b01111;
    cyc(0, "ill_t0", F_T0);
    cyc(0, "ill_t1", F_T1A);
    cyc(0, "ill_t2", F_T2);
    cyc(0, "ill_t3", ILL | DONE);
    cyc(0, "ill_next_t0", F_T0);

    // halt holds with run high until clear
    do_reset(0, "reset_halt");
    start(5'b11011);
    cyc(0, "halt_t0", F_T0);
    cyc(0, "halt_t1", F_T1A);
    cyc(0, "halt_t2", F_T2);
    cyc(0, "halt_a", HALT);
    cyc(0, "halt_b", HALT);
    cyc(0, "halt_c", HALT);
    clear = 1'b0;
    #1;
    check("halt_clear", obs_v[0], 27'd0);
    #1;
    run   = 1'b0;
    clear = 1'b1;
    cyc(0, "post_halt_idle", 27'd0);

    // addi interrupted by clear in T4: outputs drop without a clock edge
    do_reset(0, "reset_addi");
    start(5'b01100);
    cyc(0, "addi_t0", F_T0);
    cyc(0, "addi_t1", F_T1A);
    cyc(0, "addi_t2", F_T2);
    cyc(0, "addi_t3", GRB | ROUT | YIN);
    cyc(0, "addi_t4", CSIGN | ZLIN);
    #1;
    clear = 1'b0;
    #1;
    check("addi_async_clear", obs_v[0], 27'd0);
    cyc(0, "addi_held_clear", 27'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
